// File: rtl/prbs_pkg.sv
// Shared types and default constants for the PRBS generator/checker.
package prbs_pkg;

  typedef enum logic {
    ST_UNLOCK = 1'b0,
    ST_LOCK   = 1'b1
  } lock_state_e;

  // PRBS31: x^31 + x^28 + 1
  localparam int DEF_DATW     = 8;
  localparam int DEF_POLYLEN  = 31;
  localparam int DEF_POLYTAP  = 28;
  localparam int DEF_SYNC_CNT = 4;
  localparam int DEF_LOSS_CNT = 4;
  localparam int DEF_ERRW     = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prbs_step.sv
// Advances the LFSR by DATW bits in one cycle and returns the predicted word.
module prbs_step
  import prbs_pkg::*;
#(
  parameter int DATW    = DEF_DATW,
  parameter int POLYLEN = DEF_POLYLEN,
  parameter int POLYTAP = DEF_POLYTAP
) (
  input  logic [POLYLEN-1:0] state_i,
  input  logic [DATW-1:0]    idat,
  input  logic               mode,
  output logic [POLYLEN-1:0] state_o,
  output logic [DATW-1:0]    pred
);

  logic [POLYLEN-1:0] s;
  logic               fb;

  // state bit k-1 holds LFSR stage k; bit 0 of the word is the earliest in time
  always_comb begin
    s    = state_i;
    fb   = 1'b0;
    pred = '0;
    for (int i = 0; i < DATW; i++) begin
      fb      = s[POLYTAP-1] ^ s[POLYLEN-1];
      pred[i] = fb;
      s       = {s[POLYLEN-2:0], (mode ? idat[i] : fb)};
    end
    state_o = s;
  end

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS word generator and self-synchronising checker with lock FSM and
// saturating error-bit counter.
module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int DATW     = DEF_DATW,
  parameter int POLYLEN  = DEF_POLYLEN,
  parameter int POLYTAP  = DEF_POLYTAP,
  parameter int SYNC_CNT = DEF_SYNC_CNT,
  parameter int LOSS_CNT = DEF_LOSS_CNT,
  parameter int ERRW     = DEF_ERRW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            mode,
  input  logic            inj_err,
  input  logic            clr_cnt,
  input  logic [DATW-1:0] idat,
  output logic [DATW-1:0] odat,
  output logic            ovld,
  output logic            locked,
  output logic            err_word,
  output logic [ERRW-1:0] err_cnt
);

  localparam int RCW  = $clog2(max_int(SYNC_CNT, LOSS_CNT) + 1);
  localparam int PCW  = $clog2(DATW + 1);
  localparam int SUMW = max_int(ERRW, PCW) + 1;

  logic [POLYLEN-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [DATW-1:0]    pred, bitmap, inj_mask;
  logic [DATW-1:0]    odat_q, odat_d;
  logic               ovld_q, ovld_d;
  logic               err_word_q, err_word_d;
  logic               locked_q, locked_d;
  logic               mode_q, mode_d;
  lock_state_e        fsm_q, fsm_d;
  logic [RCW-1:0]     clean_cnt_q, clean_cnt_d;
  logic [RCW-1:0]     bad_cnt_q, bad_cnt_d;
  logic [ERRW-1:0]    err_cnt_q, err_cnt_d;
  logic [PCW-1:0]     popcnt;
  logic [SUMW-1:0]    err_sum;
  logic               errored;

  prbs_step #(
    .DATW    (DATW),
    .POLYLEN (POLYLEN),
    .POLYTAP (POLYTAP)
  ) u_step (
    .state_i (lfsr_q),
    .idat    (idat),
    .mode    (mode),
    .state_o (lfsr_step),
    .pred    (pred)
  );

  always_comb begin
    lfsr_d      = lfsr_q;
    odat_d      = odat_q;
    ovld_d      = 1'b0;
    err_word_d  = 1'b0;
    locked_d    = locked_q;
    mode_d      = mode_q;
    fsm_d       = fsm_q;
    clean_cnt_d = clean_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;

    bitmap      = pred ^ idat;
    inj_mask    = '0;
    inj_mask[0] = inj_err;
    popcnt      = '0;
    for (int i = 0; i < DATW; i++) begin
      popcnt = popcnt + PCW'(bitmap[i]);
    end
    // an all-zero state predicts zeros forever, so it never counts as clean
    errored = (|bitmap) || (lfsr_q == '0);
    err_sum = SUMW'(err_cnt_q) + SUMW'(popcnt);

    if (mode != mode_q) begin
      mode_d      = mode;
      lfsr_d      = '1;
      fsm_d       = ST_UNLOCK;
      locked_d    = 1'b0;
      clean_cnt_d = '0;
      bad_cnt_d   = '0;
    end else if (ena) begin
      lfsr_d = lfsr_step;
      ovld_d = 1'b1;
      if (!mode_q) begin
        odat_d = pred ^ inj_mask;
      end else begin
        odat_d     = bitmap;
        err_word_d = |bitmap;
        if (fsm_q == ST_LOCK) begin
          if (err_sum > SUMW'({ERRW{1'b1}})) err_cnt_d = '1;
          else                               err_cnt_d = ERRW'(err_sum);
        end
        case (fsm_q)
          ST_UNLOCK: begin
            if (errored) begin
              clean_cnt_d = '0;
            end else if (clean_cnt_q == RCW'(SYNC_CNT - 1)) begin
              fsm_d       = ST_LOCK;
              locked_d    = 1'b1;
              clean_cnt_d = '0;
              bad_cnt_d   = '0;
            end else begin
              clean_cnt_d = clean_cnt_q + 1'b1;
            end
          end
          ST_LOCK: begin
            if (!errored) begin
              bad_cnt_d = '0;
            end else if (bad_cnt_q == RCW'(LOSS_CNT - 1)) begin
              fsm_d       = ST_UNLOCK;
              locked_d    = 1'b0;
              bad_cnt_d   = '0;
              clean_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end
          default: begin
            fsm_d    = ST_UNLOCK;
            locked_d = 1'b0;
          end
        endcase
      end
    end

    if (clr_cnt) err_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q      <= '1;
      odat_q      <= '1;
      ovld_q      <= 1'b0;
      err_word_q  <= 1'b0;
      locked_q    <= 1'b0;
      mode_q      <= mode;
      fsm_q       <= ST_UNLOCK;
      clean_cnt_q <= '0;
      bad_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      odat_q      <= odat_d;
      ovld_q      <= ovld_d;
      err_word_q  <= err_word_d;
      locked_q    <= locked_d;
      mode_q      <= mode_d;
      fsm_q       <= fsm_d;
      clean_cnt_q <= clean_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign odat     = odat_q;
  assign ovld     = ovld_q;
  assign locked   = locked_q;
  assign err_word = err_word_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: doc/prbs_gen_chk.md
PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

Interface
REQ-001 Parameter DATW, default 8: bits per data word.
REQ-002 Parameter POLYLEN, default 31: LFSR length.
REQ-003 Parameter POLYTAP, default 28: intermediate tap XORed with stage POLYLEN.
REQ-004 Parameter SYNC_CNT, default 4: consecutive clean words needed to lock.
REQ-005 Parameter LOSS_CNT, default 4: consecutive errored words needed to lose lock.
REQ-006 Parameter ERRW, default 16: error-counter width.
REQ-007 clk  input  1: single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1: synchronous, active-low reset.
REQ-009 ena  input  1: word strobe; state advances only when high.
REQ-010 mode  input  1: 0 = generate, 1 = check.
REQ-011 inj_err  input  1: generate mode only; inverts odat[0] of the current word.
REQ-012 clr_cnt  input  1: synchronous clear of err_cnt.
REQ-013 idat  input  DATW: check-mode received data, bit 0 earliest in time.
REQ-014 odat  output  DATW: generate mode = PRBS word; check mode = error bitmap.
REQ-015 ovld  output  1: odat updated this cycle.
REQ-016 locked  output  1: checker lock status.
REQ-017 err_word  output  1: one-cycle pulse when a checked word has any error bit.
REQ-018 err_cnt  output  ERRW: saturating count of errored bits while locked.

Function
REQ-019 Bit i of each word is state[POLYTAP] ^ state[POLYLEN], computed after the i earlier bits of the same word have been shifted in; DATW bits are produced per ena cycle.
REQ-020 Generate mode: on each ena cycle, the shift-in bit is the computed bit; odat <= the word (with bit 0 inverted if inj_err is high); ovld <= 1; latency is 1 cycle.
REQ-021 Check mode: the shift-in bit is idat[i] (self-synchronising); odat <= predicted ^ idat; ovld <= 1; err_word <= |bitmap.
REQ-022 A checked word is errored if its bitmap is non-zero or the pre-update LFSR state is all-zero; this prevents false lock on constant-zero input.
REQ-023 With ena low: LFSR, FSM and err_cnt hold; ovld = 0; err_word = 0; odat holds.
REQ-024 FSM UNLOCK: clean-word counter increments per clean word and clears on an errored word; reaching SYNC_CNT moves to LOCK; locked = 1 from that edge.
REQ-025 FSM LOCK: errored-word counter increments per errored word and clears on a clean word; reaching LOSS_CNT moves to UNLOCK and deasserts locked on that edge.
REQ-026 In LOCK, err_cnt += popcount(bitmap), saturating at all ones; it holds in UNLOCK and in generate mode.
REQ-027 clr_cnt with a simultaneous increment: clear wins and err_cnt = 0.
REQ-028 A mode change, sampled on any cycle: next edge sets the LFSR to all ones, the FSM to UNLOCK and both run counters to 0; err_cnt is unchanged.
REQ-029 locked is 0 in generate mode.

Reset
REQ-030 rst_n low at a clock edge: LFSR = all ones; odat = all ones; ovld = 0; err_word = 0; locked = 0; FSM = UNLOCK; run counters = 0; err_cnt = 0; ena is ignored.
REQ-031 Reset asserted mid-operation overrides all other inputs in that cycle; operation resumes from the seed on the first edge with rst_n high.

Structure
REQ-032 State encodings (UNLOCK, LOCK) and the default polynomial constants SHALL live in shared package prbs_pkg.
REQ-033 The combinational DATW-step LFSR advance (state, idat, mode -> next state, predicted word) SHALL be sub-module prbs_step, instantiated once.

Verification
REQ-034 Loopback: DATW=8, PRBS31, generator odat/ovld drive checker idat/ena for 200 words -> locked rises 4 cycles after the first valid word; err_cnt = 0; err_word never pulses.
REQ-035 A single inj_err pulse while locked -> err_cnt = 3 (errors at offsets 0, +28 and +31 bits); locked stays 1.
REQ-036 idat = 0 for 50 words after reset -> locked stays 0; err_cnt = 0.
REQ-037 While locked, drive 4 consecutive words of inverted data -> locked falls on the 4th edge; err_cnt stops counting afterwards; a return to clean data relocks after 4 clean words.
REQ-038 ERRW=4 with continuous errors while locked -> err_cnt saturates at 15; clr_cnt pulsed together with an error -> 0.
REQ-039 rst_n pulsed low mid-stream, and a mode toggle -> all outputs match REQ-030 or REQ-028 on the next edge.
